// File: rtl/tag_dispatch_pkg.sv
// Shared definitions for the tag dispatch slice: width helper and FSM encodings.
package tag_dispatch_pkg;

   // Ceiling log2 with a floor of 1, matching the arbitration tree's tag sizing.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      int unsigned x;
      r = 0;
      x = (v > 32'd0) ? v - 32'd1 : 32'd0;
      while (x > 32'd0) begin
         r = r + 32'd1;
         x = x >> 1;
      end
      return (r == 32'd0) ? 32'd1 : r;
   endfunction

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2
   } state_e;

endpackage

// File: rtl/tag_fifo.sv
// Small in-order tag queue with occupancy count; pushes are dropped when full.
module tag_fifo
   import tag_dispatch_pkg::*;
#(
   parameter int unsigned TAG_SZ = 2,
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned CNT_SZ = clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic              pop,
   input  logic [TAG_SZ-1:0] wdata,
   output logic [TAG_SZ-1:0] head_c,
   output logic [CNT_SZ-1:0] count,
   output logic              full_c,
   output logic              empty_c
);

   localparam int unsigned PTR_SZ = clog2(DEPTH);

   logic [TAG_SZ-1:0] mem [DEPTH];
   logic [PTR_SZ-1:0] wr_ptr;
   logic [PTR_SZ-1:0] rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign full_c  = (count == CNT_SZ'(DEPTH));
   assign empty_c = (count == '0);
   assign do_push = push && !full_c;
   assign do_pop  = pop && !empty_c;
   assign head_c  = mem[rd_ptr];

   // Storage needs no reset; count guards every read.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_SZ'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_SZ'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_SZ'(1);
            2'b01:   count <= count - CNT_SZ'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/tag_dispatch.sv
// Consumer end of the tag arbitration tree: queues winning tags, then starts and
// holds one agent at a time until it reports done.
module tag_dispatch
   import tag_dispatch_pkg::*;
#(
   parameter int unsigned N      = 4,
   parameter int unsigned TAG_SZ = clog2(N),
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned CNT_SZ = clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [TAG_SZ-1:0] tag_in,
   input  logic              rdy_in,
   output logic              ack_out,
   output logic [N-1:0]      go_out,
   output logic [N-1:0]      sel_out,
   input  logic [N-1:0]      done_in,
   output logic              busy,
   output logic [CNT_SZ-1:0] count_out,
   output logic              err
);

   localparam logic [N-1:0] ONE = N'(1);

   state_e            state_q, state_d;
   logic [TAG_SZ-1:0] cur_tag_q, cur_tag_d;
   logic [N-1:0]      go_d, sel_d;
   logic              err_d;
   logic              pop;
   logic [TAG_SZ-1:0] head_c;
   logic              full_c;
   logic              empty_c;
   logic              head_ok;

   // No full-bypass: a same-cycle pop never frees a slot for the push.
   assign ack_out = rst_n && rdy_in && !full_c;
   assign head_ok = (32'(head_c) < N);

   tag_fifo #(
      .TAG_SZ (TAG_SZ),
      .DEPTH  (DEPTH),
      .CNT_SZ (CNT_SZ)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (ack_out),
      .pop     (pop),
      .wdata   (tag_in),
      .head_c  (head_c),
      .count   (count_out),
      .full_c  (full_c),
      .empty_c (empty_c)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cur_tag_q <= '0;
         go_out    <= '0;
         sel_out   <= '0;
         busy      <= 1'b0;
         err       <= 1'b0;
      end else begin
         state_q   <= state_d;
         cur_tag_q <= cur_tag_d;
         go_out    <= go_d;
         sel_out   <= sel_d;
         busy      <= (state_d != IDLE);
         err       <= err_d;
      end
   end

   // Outputs are computed for the next state so they land registered in that state.
   always_comb begin
      state_d   = state_q;
      cur_tag_d = cur_tag_q;
      go_d      = '0;
      sel_d     = sel_out;
      err_d     = 1'b0;
      pop       = 1'b0;
      case (state_q)
         IDLE: begin
            if (!empty_c) begin
               pop = 1'b1;
               if (head_ok) begin
                  cur_tag_d = head_c;
                  state_d   = START;
                  go_d      = ONE << head_c;
                  sel_d     = ONE << head_c;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         START: state_d = WAIT;
         WAIT: begin
            if (done_in[cur_tag_q]) begin
               state_d = IDLE;
               sel_d   = '0;
            end
         end
         default: begin
            state_d = IDLE;
            sel_d   = '0;
         end
      endcase
   end

endmodule
